// File: rtl/arm_mc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ARM-subset core; owns PC, CPSR flags
// and a sticky memory-timeout fault. Define ARM_BYTE_ACCESS_EN to honour the B bit (LDRB/STRB).
module arm_mc_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                MEM_WAIT_MAX = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [3:0]        rf_ra1,
  output logic [3:0]        rf_ra2,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  output logic [3:0]        rf_wa,
  output logic [31:0]       rf_wd,
  output logic              rf_we,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_y,
  input  logic [3:0]        alu_nzcv,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        cpsr_nzcv,
  output logic              fault
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [31:0] WAIT_LAST = (MEM_WAIT_MAX > 0) ? 32'(MEM_WAIT_MAX - 1) : 32'd0;

  state_t            state, state_nx;
  logic [31:0]       instr;
  logic [31:0]       op_a, op_b;
  logic [31:0]       result;
  logic [31:0]       eff;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       st_data;
  logic [3:0]        st_be;
  logic              wb_rn;
  logic [31:0]       wait_cnt;

  logic [3:0]         cond, opcode, rn, rd, rm;
  logic               is_dp, is_mem, is_br, imm_op, s_bit, p_bit, u_bit, w_bit, l_bit, link_bit;
  logic               is_test, mem_wb, byte_acc, dec_pass, waiting, wait_hit;
  logic [31:0]        op2, eff_c, addr_c, wdata_c, load_c, link;
  logic [3:0]         be_c;
  logic signed [31:0] br_off;
  logic [ADDR_W-1:0]  pc_seq, br_target;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return cf;
      4'h3:    return !cf;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return cf && !z;
      4'h9:    return !cf || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
    return (v >> sh) | (v << (6'd32 - {1'b0, sh}));
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] d, input logic [1:0] a,
                                            input logic byt);
    if (byt) return {24'h0, d[{a, 3'b000} +: 8]};
    return d;
  endfunction

  assign cond     = instr[31:28];
  assign opcode   = instr[24:21];
  assign rn       = instr[19:16];
  assign rd       = instr[15:12];
  assign rm       = instr[3:0];
  assign is_dp    = instr[27:26] == 2'b00;
  assign is_mem   = instr[27:26] == 2'b01;
  assign is_br    = instr[27:25] == 3'b101;
  assign imm_op   = instr[25];
  assign s_bit    = instr[20];
  assign p_bit    = instr[24];
  assign u_bit    = instr[23];
  assign w_bit    = instr[21];
  assign l_bit    = instr[20];
  assign link_bit = instr[24];
  assign is_test  = opcode[3:2] == 2'b10;
  assign mem_wb   = w_bit || !p_bit;
`ifdef ARM_BYTE_ACCESS_EN
  assign byte_acc = instr[22];
`else
  assign byte_acc = 1'b0;
`endif

  // Unsupported encodings (class 11, block transfers) retire like a failed condition.
  assign dec_pass = cond_pass(cond, cpsr_nzcv) && (is_dp || is_mem || is_br);

  assign op2     = imm_op ? ror32({24'h0, instr[7:0]}, {instr[11:8], 1'b0})
                          : op_b << instr[11:7];
  assign eff_c   = u_bit ? op_a + {20'h0, instr[11:0]} : op_a - {20'h0, instr[11:0]};
  assign addr_c  = p_bit ? eff_c : op_a;
  assign wdata_c = byte_acc ? {4{op_b[7:0]}} : op_b;
  assign be_c    = byte_acc ? (4'b0001 << addr_c[1:0]) : 4'b1111;
  assign load_c  = load_lane(dmem_rdata, mem_addr[1:0], byte_acc);

  assign br_off    = {{6{instr[23]}}, instr[23:0], 2'b00};
  assign pc_seq    = pc + ADDR_W'(4);
  assign br_target = pc + ADDR_W'(8) + ADDR_W'(br_off);
  assign link      = 32'(pc_seq);

  assign waiting  = ((state == FETCH) && !imem_ready) || ((state == MEM) && !dmem_ready);
  assign wait_hit = waiting && (MEM_WAIT_MAX > 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx   = state;
    imem_req   = 1'b0;
    imem_addr  = '0;
    rf_ra1     = 4'h0;
    rf_ra2     = 4'h0;
    rf_wa      = 4'h0;
    rf_wd      = 32'h0;
    rf_we      = 1'b0;
    alu_op     = 4'h0;
    alu_a      = 32'h0;
    alu_b      = 32'h0;
    dmem_addr  = '0;
    dmem_wdata = 32'h0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'h0;
    case (state)
      FETCH: begin
        imem_req  = !rst;
        imem_addr = rst ? '0 : pc;
        if (imem_ready)    state_nx = DECODE;
        else if (wait_hit) state_nx = HALT;
      end
      DECODE: begin
        if (dec_pass) begin
          rf_ra1 = rn;
          if (is_dp && !imm_op)      rf_ra2 = rm;
          else if (is_mem && !l_bit) rf_ra2 = rd;
          state_nx = EXEC;
        end else begin
          state_nx = FETCH;
        end
      end
      EXEC: begin
        if (is_dp) begin
          alu_op   = opcode;
          alu_a    = op_a;
          alu_b    = op2;
          state_nx = WB;
        end else if (is_mem) begin
          state_nx = MEM;
        end else begin
          state_nx = link_bit ? WB : FETCH;
        end
      end
      MEM: begin
        dmem_addr  = mem_addr;
        dmem_wdata = l_bit ? 32'h0 : st_data;
        dmem_re    = l_bit;
        dmem_we    = !l_bit;
        dmem_be    = st_be;
        if (dmem_ready)    state_nx = WB;
        else if (wait_hit) state_nx = HALT;
      end
      WB: begin
        state_nx = FETCH;
        if (is_br) begin
          rf_we = 1'b1;
          rf_wa = 4'd14;
          rf_wd = result;
        end else if (is_dp) begin
          rf_we = !is_test;
          rf_wa = rd;
          rf_wd = result;
        end else if (l_bit && !wb_rn) begin
          // Load data goes first; base writeback follows unless it would clobber it.
          rf_we = 1'b1;
          rf_wa = rd;
          rf_wd = result;
          if (mem_wb && (rn != rd)) state_nx = WB;
        end else if (mem_wb) begin
          rf_we = 1'b1;
          rf_wa = rn;
          rf_wd = eff;
        end
      end
      default: state_nx = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      cpsr_nzcv <= 4'h0;
      fault     <= 1'b0;
      wb_rn     <= 1'b0;
      wait_cnt  <= 32'h0;
    end else begin
      state    <= state_nx;
      wait_cnt <= waiting ? wait_cnt + 32'd1 : 32'h0;
      wb_rn    <= (state == WB) && (state_nx == WB);
      if (wait_hit) fault <= 1'b1;
      case (state)
        DECODE: if (!dec_pass) pc <= pc_seq;
        EXEC: begin
          if (is_dp && (s_bit || is_test)) cpsr_nzcv <= alu_nzcv;
          if (is_br) pc <= br_target;
        end
        WB: if ((state_nx == FETCH) && !is_br) pc <= pc_seq;
        default: ;
      endcase
    end
  end

  // Datapath holding registers carry no reset; every output using them is gated by state.
  always_ff @(posedge clk) begin
    case (state)
      FETCH: if (imem_ready) instr <= imem_rdata;
      DECODE: begin
        op_a <= rf_rd1;
        op_b <= rf_rd2;
      end
      EXEC: begin
        result   <= is_br ? link : alu_y;
        eff      <= eff_c;
        mem_addr <= addr_c[ADDR_W-1:0];
        st_data  <= wdata_c;
        st_be    <= be_c;
      end
      MEM: if (dmem_ready) result <= load_c;
      default: ;
    endcase
  end

endmodule

// File: doc/arm_mc_sequencer.md
Name: arm_mc_sequencer

Overview:
- Parametrised multicycle control sequencer for the ARM-subset core.
- Owns its own phase FSM, which replaces the externally supplied 2-bit state.
- Owns a registered PC and a registered CPSR.
- Sequences data-processing, LDR/STR (pre/post index, writeback, optional byte) and B/BL between the instruction memory, register file, external ALU and data memory, using ready handshakes.

Parameters:
- ADDR_W, 32, width of PC and of both memory addresses (16..32).
- RESET_PC, 0, PC value loaded on reset.
- MEM_WAIT_MAX, 0, maximum wait cycles on any memory handshake; 0 means unlimited.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_rdata  in  32  instruction
- imem_ready  in  1  instruction valid this cycle
- rf_ra1, rf_ra2  out  4 each  register read addresses (asynchronous-read regfile)
- rf_rd1, rf_rd2  in  32 each  register read data
- rf_wa  out  4  write address
- rf_wd  out  32  write data
- rf_we  out  1  write enable
- alu_op  out  4  ALU opcode (instr[24:21])
- alu_a, alu_b  out  32 each  ALU operands
- alu_y  in  32  ALU result
- alu_nzcv  in  4  ALU flags
- dmem_addr  out  ADDR_W  data address
- dmem_wdata  out  32  store data
- dmem_re, dmem_we  out  1 each  read / write strobe
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  load data
- dmem_ready  in  1  access complete
- pc  out  ADDR_W  current PC
- cpsr_nzcv  out  4  flags
- fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (asynchronous, immediate):
  - state = FETCH, pc = RESET_PC, cpsr_nzcv = 0, fault = 0.
  - All strobes/enables low; all address/data outputs 0.
  - Reset mid-access abandons the access; no write completes.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req = 1 until imem_ready.
  - On imem_ready: latch instr, go to DECODE.
- DECODE:
  - Evaluate cond against registered cpsr:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V.
    - GT !Z&(N==V), LE Z|(N!=V), AL 1.
    - cond 1111 is treated as fail.
  - Fail: pc += 4, go to FETCH; no side effects.
  - Pass: drive rf_ra1 = Rn; drive rf_ra2 = Rm for register-operand DP, or Rd for STR; go to EXEC.
- EXEC:
  - Operand-2, immediate form: imm8 rotated right by 2*rot4.
  - Operand-2, register form: Rm LSL imm5; other shift types are treated as LSL.
  - DP:
    - alu_a = rf_rd1; alu_b = operand2; alu_op = opcode.
    - Latch alu_y.
    - If S = 1, or opcode is 10xx (TST/TEQ/CMP/CMN), cpsr_nzcv <= alu_nzcv.
    - Next state WB.
  - LDR/STR:
    - offset = imm12.
    - eff = U ? Rn + off : Rn - off.
    - addr = P ? eff : Rn.
    - Next state MEM.
  - B/BL:
    - pc <= pc + 8 + (sext(imm24) << 2).
    - BL: latch link = old pc + 4, go to WB.
    - B: go to FETCH.
- MEM:
  - Hold dmem_re (LDR) or dmem_we (STR), addr, wdata and be stable until dmem_ready.
  - Word access: be = 1111.
  - Then go to WB.
- WB:
  - Exactly one rf_we pulse.
  - DP: Rd <= result. TST/TEQ/CMP/CMN write nothing.
  - LDR: Rd <= load data.
  - STR with W = 1, or post-index (P = 0): Rn <= eff.
  - LDR with writeback: Rn <= eff is written in an extra WB cycle after the Rd write. If Rd == Rn, the load value wins.
  - BL: r14 <= link.
  - Non-branch instructions then do pc += 4 and go to FETCH.
- PC arithmetic wraps modulo 2^ADDR_W.
- Instruction latency:
  - DP: 4 cycles plus fetch wait.
  - LDR/STR: 5 cycles plus waits.
  - B: 3 cycles.
- Timeout:
  - If MEM_WAIT_MAX > 0 and any ready stays low for MEM_WAIT_MAX consecutive cycles: fault <= 1, state = HALT.
  - HALT holds all strobes low until reset.

Optional Feature:
- Macro: ARM_BYTE_ACCESS_EN.
- Defined:
  - B bit honoured.
  - LDRB: Rd = zero-extended byte selected by addr[1:0].
  - STRB: wdata = byte replicated ×4; be = one-hot from addr[1:0].
- Undefined: B bit ignored; all accesses are word with be = 1111.

Test Plan:
- Reset while in MEM with dmem_we = 1 → dmem_we drops to 0 immediately; pc = RESET_PC, cpsr = 0, fault = 0.
- MOVS r1,#0 (imm), then ADDEQ r2,r1,#5 → cpsr Z = 1; r2 = 5 written once; pc advances by 8.
- CMP r0,r0 (r0 = 3), then BNE +4 → BNE fails; pc = old + 4; no rf_we.
- CMP r0,r0, then BLEQ with imm24 = 2 at pc 0x20 → pc = 0x30; r14 = 0x24.
- STR r3,[r4,#8]! (r4 = 0x100, r3 = 0xDEADBEEF), dmem_ready delayed 3 cycles → dmem_addr = 0x108 held throughout; be = 1111; r4 = 0x108 afterwards.
- MEM_WAIT_MAX = 4, dmem_ready never asserted → fault = 1 after 4 wait cycles; HALT.
- With ARM_BYTE_ACCESS_EN: LDRB from addr 0x102 with rdata 0x11223344 → Rd = 0x00000022.
